// File: rtl/conv3x3_cfg_if.sv
// Window/coefficient/result bundle for the configurable 3x3 convolution engine.
interface conv3x3_cfg_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
);
  logic [9*DATA_W-1:0]       i_pixel_data;
  logic                      i_pixel_data_valid;
  logic [3:0]                i_shift;
  logic                      i_mode;
  logic                      i_coef_we;
  logic [3:0]                i_coef_addr;
  logic signed [COEF_W-1:0]  i_coef_data;
  logic [DATA_W-1:0]         o_convolved_data;
  logic                      o_convolved_data_valid;
  logic                      o_sat;

  modport master (
    output i_pixel_data, i_pixel_data_valid, i_shift, i_mode,
           i_coef_we, i_coef_addr, i_coef_data,
    input  o_convolved_data, o_convolved_data_valid, o_sat
  );

  modport slave (
    input  i_pixel_data, i_pixel_data_valid, i_shift, i_mode,
           i_coef_we, i_coef_addr, i_coef_data,
    output o_convolved_data, o_convolved_data_valid, o_sat
  );
endinterface

// File: rtl/conv3x3_cfg.sv
// 3x3 convolution with loadable signed kernel, abs/signed output mode,
// rounded power-of-two normalisation and clamp to the unsigned pixel range.
// Registers: products (edge N), sum (N+1), |S| or S with shift (N+2),
// rounded/clamped pixel (N+3). Abs and rounding sit in separate stages to
// keep the carry chains behind each register short.
module conv3x3_cfg #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  conv3x3_cfg_if.slave   bus
);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = DATA_W + COEF_W + 5;

  localparam logic signed [COEF_W-1:0] LAP_CENTRE = COEF_W'(8);
  localparam logic signed [COEF_W-1:0] LAP_EDGE   = '1;

  logic signed [COEF_W-1:0] r_coef [9];
  logic signed [PROD_W-1:0] r_prod [9];
  logic signed [PROD_W-1:0] w_prod [9];
  logic [3:0]               r_shift1, r_shift2, r_shift3;
  logic                     r_mode1, r_mode2;
  logic                     r_vld1, r_vld2, r_vld3, r_vld4;
  logic signed [ACC_W-1:0]  r_sum, w_sum, r_a, w_a;
  logic signed [ACC_W:0]    w_a_ext, w_bias, w_round;
  logic [DATA_W-1:0]        r_data, w_data;
  logic                     r_sat, w_sat;

  // Coefficient bank; resets to the Laplacian kernel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 9; k++) r_coef[k] <= (k == 4) ? LAP_CENTRE : LAP_EDGE;
    end else if (bus.i_coef_we) begin
      for (int k = 0; k < 9; k++)
        if (bus.i_coef_addr == 4'(k)) r_coef[k] <= bus.i_coef_data;
    end
  end

  // Per-tap signed products; pixel zero-extended so it is never negative.
  always_comb begin
    for (int k = 0; k < 9; k++)
      w_prod[k] = $signed({{(COEF_W+1){1'b0}}, bus.i_pixel_data[k*DATA_W +: DATA_W]})
                  * PROD_W'(r_coef[k]);
  end

  // Stage 1: capture products with the window's shift/mode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 9; k++) r_prod[k] <= '0;
      r_shift1 <= '0;
      r_mode1  <= 1'b0;
      r_vld1   <= 1'b0;
    end else begin
      r_vld1 <= bus.i_pixel_data_valid;
      if (bus.i_pixel_data_valid) begin
        for (int k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
        r_shift1 <= bus.i_shift;
        r_mode1  <= bus.i_mode;
      end
    end
  end

  // Adder tree over sign-extended products.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 9; k++) w_sum = w_sum + ACC_W'(r_prod[k]);
  end

  // Stage 2: capture the sum.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum    <= '0;
      r_shift2 <= '0;
      r_mode2  <= 1'b0;
      r_vld2   <= 1'b0;
    end else begin
      r_vld2 <= r_vld1;
      if (r_vld1) begin
        r_sum    <= w_sum;
        r_shift2 <= r_shift1;
        r_mode2  <= r_mode1;
      end
    end
  end

  // Absolute value in mode 1; the sum can never reach the most negative code.
  always_comb begin
    w_a = r_sum;
    if (r_mode2 && r_sum[ACC_W-1]) w_a = -r_sum;
  end

  // Stage 3a: capture the (possibly rectified) sum with its shift.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a      <= '0;
      r_shift3 <= '0;
      r_vld3   <= 1'b0;
    end else begin
      r_vld3 <= r_vld2;
      if (r_vld2) begin
        r_a      <= w_a;
        r_shift3 <= r_shift2;
      end
    end
  end

  // Round half up, arithmetic shift, then clamp to [0, 2^DATA_W-1].
  always_comb begin
    w_a_ext = {r_a[ACC_W-1], r_a};
    w_bias  = '0;
    if (r_shift3 != 4'd0) w_bias[5'(r_shift3) - 5'd1] = 1'b1;
    w_round = (w_a_ext + w_bias) >>> r_shift3;
    w_data  = w_round[DATA_W-1:0];
    w_sat   = 1'b0;
    if (w_round[ACC_W]) begin
      w_data = '0;
      w_sat  = 1'b1;
    end else if (w_round[ACC_W-1:DATA_W] != '0) begin
      w_data = '1;
      w_sat  = 1'b1;
    end
  end

  // Stage 3b: output register; holds its pixel while no result is valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_sat  <= 1'b0;
      r_vld4 <= 1'b0;
    end else begin
      r_vld4 <= r_vld3;
      if (r_vld3) begin
        r_data <= w_data;
        r_sat  <= w_sat;
      end
    end
  end

  assign bus.o_convolved_data       = r_data;
  assign bus.o_convolved_data_valid = r_vld4;
  assign bus.o_sat                  = r_sat;
endmodule

// File: tb/tb_conv3x3_cfg.sv
// Self-checking bench for conv3x3_cfg: arithmetic reference model with a
// 3-edge result delay, per-cycle compare, plus literal directed expectations.
module tb_conv3x3_cfg;
  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv3x3_cfg_if #(.DATA_W(DW), .COEF_W(CW)) bus ();
  conv3x3_cfg #(.DATA_W(DW), .COEF_W(CW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: kernel, results in flight, visible output.
  int         coef_m [9];
  logic       p_vld  [3];
  logic [8:0] p_res  [3];
  logic       m_vld  = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_sat  = 1'b0;

  // Returns {sat, pixel} straight from the arithmetic definition.
  function automatic logic [8:0] model_px(input logic [71:0] pix, input int c[9],
                                          input int sh, input bit md);
    longint sum = 0;
    longint a;
    longint r;
    for (int k = 0; k < 9; k++) sum += longint'(pix[k*8 +: 8]) * longint'(c[k]);
    a = (md && sum < 0) ? -sum : sum;
    r = (sh == 0) ? a : ((a + (longint'(1) << (sh - 1))) >>> sh);
    if (r < 0) return {1'b1, 8'd0};
    if (r > 255) return {1'b1, 8'd255};
    return {1'b0, r[7:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) coef_m[k] <= (k == 4) ? 8 : -1;
      for (int k = 0; k < 3; k++) begin
        p_vld[k] <= 1'b0;
        p_res[k] <= '0;
      end
      m_vld  <= 1'b0;
      m_data <= '0;
      m_sat  <= 1'b0;
    end else begin
      m_vld <= p_vld[2];
      if (p_vld[2]) begin
        m_data <= p_res[2][7:0];
        m_sat  <= p_res[2][8];
      end
      p_vld[2] <= p_vld[1];
      p_res[2] <= p_res[1];
      p_vld[1] <= p_vld[0];
      p_res[1] <= p_res[0];
      p_vld[0] <= bus.i_pixel_data_valid;
      p_res[0] <= model_px(bus.i_pixel_data, coef_m, int'(bus.i_shift), bus.i_mode);
      if (bus.i_coef_we && bus.i_coef_addr <= 4'd8)
        coef_m[bus.i_coef_addr] <= int'(bus.i_coef_data);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    n_checks++;
    if (bus.o_convolved_data_valid !== m_vld) begin
      n_errors++;
      $display("FAIL cyc_valid t=%0t: got %b expected %b", $time, bus.o_convolved_data_valid, m_vld);
    end
    n_checks++;
    if (bus.o_convolved_data !== m_data) begin
      n_errors++;
      $display("FAIL cyc_data t=%0t: got %0d expected %0d", $time, bus.o_convolved_data, m_data);
    end
    if (m_vld) begin
      n_checks++;
      if (bus.o_sat !== m_sat) begin
        n_errors++;
        $display("FAIL cyc_sat t=%0t: got %b expected %b", $time, bus.o_sat, m_sat);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mk(input logic [7:0] centre, input logic [7:0] other);
    logic [71:0] px = {9{other}};
    px[4*8 +: 8] = centre;
    return px;
  endfunction

  task automatic win(input logic [71:0] px, input int sh, input bit md);
    bus.i_pixel_data       = px;
    bus.i_shift            = 4'(sh);
    bus.i_mode             = md;
    bus.i_pixel_data_valid = 1'b1;
  endtask

  task automatic one_window(input string nm, input logic [71:0] px, input int sh,
                            input bit md, input int exp_d, input int exp_s);
    win(px, sh, md);
    tick();
    bus.i_pixel_data_valid = 1'b0;
    tick();
    tick();
    chk({nm, "_early"}, int'(bus.o_convolved_data_valid), 0);
    tick();
    chk({nm, "_vld"}, int'(bus.o_convolved_data_valid), 1);
    chk({nm, "_data"}, int'(bus.o_convolved_data), exp_d);
    chk({nm, "_sat"}, int'(bus.o_sat), exp_s);
  endtask

  task automatic rand_cycle(input bit allow_we);
    logic [95:0] r96 = {$urandom, $urandom, $urandom};
    bus.i_pixel_data       = r96[71:0];
    bus.i_pixel_data_valid = ($urandom_range(0, 3) != 0);
    bus.i_shift            = 4'($urandom_range(0, 15));
    bus.i_mode             = 1'($urandom_range(0, 1));
    bus.i_coef_we          = allow_we && ($urandom_range(0, 4) == 0);
    bus.i_coef_addr        = 4'($urandom_range(0, 15));
    bus.i_coef_data        = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 6) - 3);
  endtask

  initial begin
    bus.i_pixel_data       = '0;
    bus.i_pixel_data_valid = 1'b0;
    bus.i_shift            = '0;
    bus.i_mode             = 1'b0;
    bus.i_coef_we          = 1'b0;
    bus.i_coef_addr        = '0;
    bus.i_coef_data        = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", int'(bus.o_convolved_data_valid), 0);
    chk("rst_data", int'(bus.o_convolved_data), 0);
    chk("rst_sat", int'(bus.o_sat), 0);
    rst = 1'b0;
    tick();
    chk("idle_vld", int'(bus.o_convolved_data_valid), 0);
    chk("idle_data", int'(bus.o_convolved_data), 0);

    one_window("lap_flat", {9{8'd100}}, 0, 1'b0, 0, 0);
    one_window("lap_peak", mk(8'd200, 8'd10), 0, 1'b0, 255, 1);
    one_window("neg_m0", mk(8'd0, 8'd50), 0, 1'b0, 0, 1);
    one_window("neg_m1s0", mk(8'd0, 8'd50), 0, 1'b1, 255, 1);
    one_window("neg_m1s2", mk(8'd0, 8'd50), 2, 1'b1, 100, 0);

    // Box kernel of ones.
    for (int k = 0; k < 9; k++) begin
      bus.i_coef_we   = 1'b1;
      bus.i_coef_addr = 4'(k);
      bus.i_coef_data = 8'sd1;
      tick();
    end
    bus.i_coef_we = 1'b0;
    one_window("box80", {9{8'd80}}, 3, 1'b0, 90, 0);

    // Write coinciding with a window: that window keeps the old kernel.
    win({9{8'd80}}, 3, 1'b0);
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = 4'd4;
    bus.i_coef_data = 8'sd9;
    tick();
    bus.i_coef_we = 1'b0;
    tick();
    bus.i_pixel_data_valid = 1'b0;
    tick();
    tick();
    chk("coh_old_vld", int'(bus.o_convolved_data_valid), 1);
    chk("coh_old_data", int'(bus.o_convolved_data), 90);
    tick();
    chk("coh_new_vld", int'(bus.o_convolved_data_valid), 1);
    chk("coh_new_data", int'(bus.o_convolved_data), 170);
    tick();
    chk("coh_hold_vld", int'(bus.o_convolved_data_valid), 0);
    chk("coh_hold_data", int'(bus.o_convolved_data), 170);

    // Ten windows with a two-cycle gap; the per-cycle compare tracks the pattern.
    for (int i = 0; i < 12; i++) begin
      rand_cycle(1'b0);
      bus.i_pixel_data_valid = !(i == 4 || i == 5);
      tick();
    end
    bus.i_pixel_data_valid = 1'b0;
    repeat (4) tick();

    // Long randomized run including kernel rewrites and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      rand_cycle(1'b1);
      tick();
    end
    bus.i_coef_we = 1'b0;

    // Reset in the middle of a dense stream.
    for (int i = 0; i < 6; i++) begin
      rand_cycle(1'b0);
      bus.i_pixel_data_valid = 1'b1;
      tick();
    end
    #2 rst = 1'b1;
    bus.i_pixel_data_valid = 1'b0;
    #1;
    chk("midrst_vld", int'(bus.o_convolved_data_valid), 0);
    chk("midrst_data", int'(bus.o_convolved_data), 0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("post_rst_vld", int'(bus.o_convolved_data_valid), 0);
    one_window("post_rst_lap", mk(8'd200, 8'd10), 0, 1'b0, 255, 1);

    // Writes to addresses past the bank are dropped.
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = 4'd12;
    bus.i_coef_data = 8'sd5;
    tick();
    bus.i_coef_we = 1'b0;
    one_window("addr12_flat", {9{8'd77}}, 0, 1'b0, 0, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
